ntt_job_arbiter: RTL and testbench
==================================

Name: ntt_job_arbiter

Overview:
- Round-robin scheduler that shares one ntt_memory_wrapper instance (single NTT/INTT SDF core plus its address generation) between NREQ requesters.
- Per job:
  - Grants one requester.
  - Clears the core with a synchronous core reset pulse, because the core's address counters and finish flag only clear on reset.
  - Issues the start pulse and holds the NTT/INTT mode stable.
  - Waits for the core's level finish, then returns a done pulse to the owner.
- Sits between the polynomial-level controllers and the NTT core; the granted requester's BRAM port is muxed onto the core's read_address/write_address/wea outside this block, using grant.

Parameters:
- NREQ, 4, number of requesters (2..8).
- RST_CYCLES, 2, cycles core_rst is held high before start (>=1).
- TIMEOUT_CYCLES, 65536, watchdog limit in RUN; used only with the optional feature.
- CNT_W, 17, width of the watchdog counter; must satisfy 2**CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- req  in  NREQ  per-requester job request, level
- req_intt  in  NREQ  per-requester mode: 1 = INTT, 0 = NTT; sampled at grant
- grant  out  NREQ  one-hot owner of the core, 0 when idle
- done  out  NREQ  one-cycle completion pulse to the owner
- err  out  1  one-cycle timeout pulse, coincident with done
- busy  out  1  high whenever state != IDLE
- core_rst  out  1  synchronous reset to ntt_memory_wrapper
- core_start  out  1  one-cycle start pulse to the core
- core_intt  out  1  registered mode, stable for the whole job
- core_finish  in  1  core finish, level, stays high until core_rst

Behaviour:
- Reset (async assert, sync release via clk): state=IDLE, grant=0, done=0, err=0, busy=0, core_rst=1, core_start=0, core_intt=0, rr pointer=NREQ-1. Holding core_rst high in reset keeps the core cleared.
- All outputs are registered.
- FSM states: IDLE, CLR, START, RUN, DONE.
- IDLE:
  - core_rst=1.
  - If any req bit is set, choose the first set bit searching from ptr+1 upward with wrap.
  - Next cycle: grant=onehot(sel), core_intt=req_intt[sel], ptr=sel, state=CLR.
- CLR:
  - core_rst=1 for RST_CYCLES cycles, counted by rst_cnt.
  - Then state=START.
  - core_finish is ignored in CLR and START, since a stale finish from the previous job is still high until core_rst takes effect.
- START:
  - core_rst=0, core_start=1 for exactly one cycle.
  - Then state=RUN.
- RUN:
  - Waits for core_finish=1.
  - Then state=DONE.
- DONE:
  - done[sel]=1 for one cycle, grant still asserted.
  - Next cycle: grant=0, state=IDLE, core_rst=1.
- Minimum gap between jobs is 1 IDLE cycle.
- Per-job overhead around the core runtime: 1 (grant) + RST_CYCLES + 1 (start) + 1 (finish sample) + 1 (done).
- If the owner drops req mid-job, the job still runs to completion and done is still pulsed; abort is not supported.
- Changes to req_intt after grant are ignored.
- If the owner still holds req after done, its request is re-arbitrated; because ptr advanced, other pending requesters are served first.
- Simultaneous requests are granted strictly in rotating order. Starvation is impossible: worst-case wait is NREQ-1 jobs.
- Asserting rst mid-job aborts immediately to the reset values. No done is issued for the aborted job.
- grant is always one-hot or zero; done is always a subset of grant.

Optional Feature:
- Macro: NTT_JOB_ARBITER_TIMEOUT_EN.
- With the macro:
  - A watchdog counter, CNT_W bits, clears on entry to RUN and increments each RUN cycle.
  - If it reaches TIMEOUT_CYCLES-1 without core_finish, the FSM goes to DONE with err=1 and done[sel]=1 on the same cycle.
  - If core_finish and the timeout occur in the same cycle, finish wins and err=0.
- Without the macro: no counter is built, err is tied to 0, and RUN waits indefinitely.

Decomposition:
- Shared header ntt_ctrl_pkg holds:
  - FSM state encoding localparams (IDLE=0, CLR=1, START=2, RUN=3, DONE=4, 3 bits).
  - Default NREQ.
  - The clog2 helper function.
- One sub-module, rr_arbiter:
  - Parameter NREQ.
  - Inputs: req, ptr, enable.
  - Outputs: combinational one-hot sel and a valid flag.
- The top block registers sel into grant and owns the FSM and counters.

Test Plan:
- Single job: req=4'b0010, req_intt=4'b0010, core_finish rising 300 cycles after core_start.
  - grant=4'b0010 one cycle after req.
  - core_rst high exactly 2 cycles, then core_start one cycle.
  - core_intt=1 throughout.
  - done[1] pulses 2 cycles after core_finish rises; grant returns to 0 the next cycle.
- Contention: req=4'b1111 held for 4 jobs from reset → grant order 0,1,2,3; then the 5th job returns to 0.
- Stale finish: core_finish held high entering CLR after the previous job → no early done; core_finish is ignored until RUN, and done is pulsed only after the new finish.
- Async reset in RUN: assert rst between core_start and core_finish → outputs go to reset values without a clock edge, no done pulse; a fresh req afterwards is granted normally.
- Owner drops req during RUN and changes req_intt → job completes with the original core_intt and done is still pulsed.
- With NTT_JOB_ARBITER_TIMEOUT_EN and TIMEOUT_CYCLES=64, core_finish never asserted → err=1 and done=1 together 64 cycles after RUN entry, then IDLE.

Source files
------------

// File: rtl/ntt_ctrl_pkg.sv
// Shared definitions for the NTT job control blocks: FSM encoding, defaults, helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ntt_ctrl_pkg;

  // Default number of requesters sharing one NTT core
  localparam int NREQ_DEFAULT = 4;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLR   = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_RUN   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    CLR   = ST_CLR,
    START = ST_START,
    RUN   = ST_RUN,
    DONE  = ST_DONE
  } state_e;

  // Ceiling log2, minimum result 1 so it can size index vectors directly
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    if (r == 0) begin
      r = 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ntt_job_arbiter_rr.sv
// Round-robin pick: first set request searching upward from ptr+1 with wrap.
// Latency: purely combinational.
// Backpressure: none; enable gates the pick, the caller decides when to latch it.
module rr_arbiter
  import ntt_ctrl_pkg::*;
#(
  parameter int NREQ  = NREQ_DEFAULT,
  parameter int PTR_W = clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [PTR_W-1:0] ptr_i,
  input  logic             enable_i,
  output logic [NREQ-1:0]  sel_o,
  output logic             valid_o
);

  logic [PTR_W-1:0] idx;
  logic             found;

  // Walk the requesters starting just after the last owner; first hit wins
  always_comb begin
    sel_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = PTR_W'((int'(ptr_i) + i) % NREQ);
      if (enable_i && !found && req_i[idx]) begin
        sel_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/ntt_job_arbiter.sv
// Round-robin job scheduler sharing one NTT/INTT core: grant, core clear, start, wait finish, done.
// Latency: grant 1 cycle after req in IDLE; done 2 cycles after core_finish rises; 1 IDLE cycle between jobs.
// Backpressure: req is a level held by the requester; it is ignored while a job is in flight (no abort).
// Optional watchdog on the RUN wait is built only when NTT_JOB_ARBITER_TIMEOUT_EN is defined.
module ntt_job_arbiter
  import ntt_ctrl_pkg::*;
#(
  parameter int NREQ           = NREQ_DEFAULT,
  parameter int RST_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int CNT_W          = 17
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] req_intt,
  output logic [NREQ-1:0] grant,
  output logic [NREQ-1:0] done,
  output logic            err,
  output logic            busy,
  output logic            core_rst,
  output logic            core_start,
  output logic            core_intt,
  input  logic            core_finish
);

  localparam int PTR_W = clog2(NREQ);
  localparam int RC_W  = clog2(RST_CYCLES);
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYCLES - 1);

  state_e            state_q, state_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic              busy_q, busy_d;
  logic              core_rst_q, core_rst_d;
  logic              core_start_q, core_start_d;
  logic              core_intt_q, core_intt_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [RC_W-1:0]   rst_cnt_q, rst_cnt_d;
  logic              finish_q, finish_d;

  logic [NREQ-1:0]   arb_sel;
  logic              arb_vld;
  logic              arb_en;
  logic [PTR_W-1:0]  sel_idx;

`ifdef NTT_JOB_ARBITER_TIMEOUT_EN
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0]  wd_q, wd_d;
  logic              err_q, err_d;
`else
  logic              unused_cfg;
  assign unused_cfg = (TIMEOUT_CYCLES > CNT_W);
`endif

  // Arbitration only matters while idle; elsewhere the pick is held off
  assign arb_en = (state_q == IDLE);

  rr_arbiter #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_rr (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .enable_i (arb_en),
    .sel_o    (arb_sel),
    .valid_o  (arb_vld)
  );

  // One-hot pick to index, becomes the next round-robin pointer
  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_sel[i]) begin
        sel_idx = PTR_W'(i);
      end
    end
  end

  // Next-state and registered-output decode
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    done_d      = '0;
    core_intt_d = core_intt_q;
    ptr_d       = ptr_q;
    rst_cnt_d   = rst_cnt_q;
    // finish is only trusted in RUN; a stale level from the last job may linger before core_rst lands
    finish_d    = (state_q == RUN) && core_finish;
`ifdef NTT_JOB_ARBITER_TIMEOUT_EN
    wd_d        = wd_q;
    err_d       = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (arb_vld) begin
          grant_d     = arb_sel;
          core_intt_d = |(req_intt & arb_sel);
          ptr_d       = sel_idx;
          rst_cnt_d   = '0;
          state_d     = CLR;
        end
      end
      CLR: begin
        if (rst_cnt_q == RC_LAST) begin
          state_d = START;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      START: begin
        state_d = RUN;
`ifdef NTT_JOB_ARBITER_TIMEOUT_EN
        wd_d    = '0;
`endif
      end
      RUN: begin
        // A finish seen on the same cycle as the timeout wins, so err stays low
        if (finish_q) begin
          state_d = DONE;
          done_d  = grant_q;
        end
`ifdef NTT_JOB_ARBITER_TIMEOUT_EN
        else if (wd_q == WD_LAST) begin
          state_d = DONE;
          done_d  = grant_q;
          err_d   = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
`endif
      end
      DONE: begin
        grant_d = '0;
        state_d = IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase

    // Core controls follow the state being entered so they line up with state_q
    core_rst_d   = (state_d == IDLE) || (state_d == CLR);
    core_start_d = (state_d == START);
    busy_d       = (state_d != IDLE);
  end

  // State and output registers; reset holds the core in its own reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      done_q       <= '0;
      busy_q       <= 1'b0;
      core_rst_q   <= 1'b1;
      core_start_q <= 1'b0;
      core_intt_q  <= 1'b0;
      ptr_q        <= PTR_W'(NREQ - 1);
      rst_cnt_q    <= '0;
      finish_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      core_rst_q   <= core_rst_d;
      core_start_q <= core_start_d;
      core_intt_q  <= core_intt_d;
      ptr_q        <= ptr_d;
      rst_cnt_q    <= rst_cnt_d;
      finish_q     <= finish_d;
    end
  end

`ifdef NTT_JOB_ARBITER_TIMEOUT_EN
  // Watchdog counter and its error pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign grant      = grant_q;
  assign done       = done_q;
  assign busy       = busy_q;
  assign core_rst   = core_rst_q;
  assign core_start = core_start_q;
  assign core_intt  = core_intt_q;

endmodule

// File: tb/tb_ntt_job_arbiter.sv
// Directed bench for ntt_job_arbiter: job table plus async-reset and watchdog sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_ntt_job_arbiter;

  localparam int NREQ       = 4;
  localparam int RST_CYCLES = 2;

  logic            clk;
  logic            rst;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] req_intt;
  logic [NREQ-1:0] grant;
  logic [NREQ-1:0] done;
  logic            err;
  logic            busy;
  logic            core_rst;
  logic            core_start;
  logic            core_intt;
  logic            core_finish;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic            do_rst;
    logic [NREQ-1:0] v_req;
    logic [NREQ-1:0] v_intt;
    int              run_len;
    logic            drop;
    logic [NREQ-1:0] exp_grant;
    logic            exp_intt;
  } vec_t;

  vec_t vecs[9];

  ntt_job_arbiter #(
    .NREQ           (NREQ),
    .RST_CYCLES     (RST_CYCLES),
    .TIMEOUT_CYCLES (64),
    .CNT_W          (17)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_intt    (req_intt),
    .grant       (grant),
    .done        (done),
    .err         (err),
    .busy        (busy),
    .core_rst    (core_rst),
    .core_start  (core_start),
    .core_intt   (core_intt),
    .core_finish (core_finish)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_grant"},      grant,      0);
    chk({tag, "_done"},       done,       0);
    chk({tag, "_err"},        err,        0);
    chk({tag, "_busy"},       busy,       0);
    chk({tag, "_core_rst"},   core_rst,   1);
    chk({tag, "_core_start"}, core_start, 0);
    chk({tag, "_core_intt"},  core_intt,  0);
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    req         = '0;
    req_intt    = '0;
    core_finish = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst = 1'b0;
  endtask

  // One full job; core_finish left high afterwards mimics a core that is only cleared by core_rst
  task automatic run_job(input vec_t v);
    int n;
    int rc;
    req      = v.v_req;
    req_intt = v.v_intt;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (grant == '0 && n < 20);
    chk("grant_latency", n, 1);
    chk("grant", grant, v.exp_grant);
    chk("core_intt_at_grant", core_intt, v.exp_intt);
    chk("busy", busy, 1);
    rc = core_rst ? 1 : 0;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
      if (!core_start && core_rst) rc++;
      if (!core_start) chk("no_done_in_clr", done, 0);
    end while (!core_start && n < 10);
    chk("core_start_seen", core_start, 1);
    chk("core_rst_cycles", rc, RST_CYCLES);
    chk("core_rst_low_in_start", core_rst, 0);
    core_finish = 1'b0;
    for (int i = 1; i <= v.run_len; i++) begin
      @(posedge clk); #1;
      if (i == 1) chk("core_start_one_cycle", core_start, 0);
      chk("no_early_done", done, 0);
      if (v.drop && i == 2) begin
        req      = '0;
        req_intt = ~v.v_intt;
      end
    end
    chk("core_intt_held", core_intt, v.exp_intt);
    core_finish = 1'b1;
    @(posedge clk); #1;
    chk("done_not_yet", done, 0);
    @(posedge clk); #1;
    chk("done", done, v.exp_grant);
    chk("err_at_done", err, 0);
    chk("grant_at_done", grant, v.exp_grant);
    @(posedge clk); #1;
    chk("grant_release", grant, 0);
    chk("done_clear", done, 0);
    chk("busy_idle", busy, 0);
    chk("core_rst_idle", core_rst, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL sim_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    vec_t v;
    int   n;

    vecs[0] = '{do_rst:1'b0, v_req:4'b0010, v_intt:4'b0010, run_len:300, drop:1'b0, exp_grant:4'b0010, exp_intt:1'b1};
    vecs[1] = '{do_rst:1'b1, v_req:4'b1111, v_intt:4'b1010, run_len:5,   drop:1'b0, exp_grant:4'b0001, exp_intt:1'b0};
    vecs[2] = '{do_rst:1'b0, v_req:4'b1111, v_intt:4'b1010, run_len:5,   drop:1'b0, exp_grant:4'b0010, exp_intt:1'b1};
    vecs[3] = '{do_rst:1'b0, v_req:4'b1111, v_intt:4'b1010, run_len:5,   drop:1'b0, exp_grant:4'b0100, exp_intt:1'b0};
    vecs[4] = '{do_rst:1'b0, v_req:4'b1111, v_intt:4'b1010, run_len:5,   drop:1'b0, exp_grant:4'b1000, exp_intt:1'b1};
    vecs[5] = '{do_rst:1'b0, v_req:4'b1111, v_intt:4'b1010, run_len:5,   drop:1'b0, exp_grant:4'b0001, exp_intt:1'b0};
    vecs[6] = '{do_rst:1'b0, v_req:4'b0100, v_intt:4'b0100, run_len:20,  drop:1'b1, exp_grant:4'b0100, exp_intt:1'b1};
    vecs[7] = '{do_rst:1'b0, v_req:4'b0011, v_intt:4'b0001, run_len:3,   drop:1'b0, exp_grant:4'b0001, exp_intt:1'b1};
    vecs[8] = '{do_rst:1'b0, v_req:4'b0011, v_intt:4'b0001, run_len:1,   drop:1'b0, exp_grant:4'b0010, exp_intt:1'b0};

    do_reset();

    for (int k = 0; k < 9; k++) begin
      if (vecs[k].do_rst) do_reset();
      run_job(vecs[k]);
    end

    // Async reset in RUN: outputs drop without a clock edge, no done for the aborted job
    req         = 4'b0001;
    req_intt    = 4'b0001;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (grant == '0 && n < 20);
    chk("ar_grant", grant, 4'b0001);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!core_start && n < 10);
    chk("ar_start", core_start, 1);
    core_finish = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    chk("ar_busy_before", busy, 1);
    chk("ar_intt_before", core_intt, 1);
    #2 rst = 1'b1;
    #1;
    chk_reset_vals("ar");
    req = '0;
    repeat (2) begin
      @(posedge clk); #1;
      chk("ar_no_done", done, 0);
    end
    rst = 1'b0;
    v = '{do_rst:1'b0, v_req:4'b0010, v_intt:4'b0000, run_len:4, drop:1'b0, exp_grant:4'b0010, exp_intt:1'b0};
    run_job(v);

`ifdef NTT_JOB_ARBITER_TIMEOUT_EN
    // Watchdog: finish never comes, done and err fire together 64 cycles after RUN entry
    req      = 4'b1000;
    req_intt = 4'b0000;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (grant == '0 && n < 20);
    chk("to_grant", grant, 4'b1000);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!core_start && n < 10);
    chk("to_start", core_start, 1);
    core_finish = 1'b0;
    req         = '0;
    for (int i = 1; i <= 64; i++) begin
      @(posedge clk); #1;
      chk("to_no_early_done", done, 0);
    end
    @(posedge clk); #1;
    chk("to_done", done, 4'b1000);
    chk("to_err", err, 1);
    @(posedge clk); #1;
    chk("to_err_clear", err, 0);
    chk("to_grant_release", grant, 0);
    chk("to_busy_idle", busy, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
